// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: operation codes, mode values,
// sequencer state encoding and the packed command width.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic MODE_ARITH = 1'b1;
  localparam logic MODE_LOGIC = 1'b0;

  // Arithmetic-mode operation codes
  localparam logic [1:0] OPER_PASS_A = 2'b00;
  localparam logic [1:0] OPER_ADD    = 2'b01;
  localparam logic [1:0] OPER_SUB_AB = 2'b10;
  localparam logic [1:0] OPER_SUB_BA = 2'b11;

  // Logic-mode operation codes
  localparam logic [1:0] OPER_AND    = 2'b00;
  localparam logic [1:0] OPER_OR     = 2'b01;
  localparam logic [1:0] OPER_XOR    = 2'b10;
  localparam logic [1:0] OPER_XNOR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_t;

  // Packed command layout, MSB first: {a, b, cin, oper, mode}
  function automatic int cmd_width(input int n);
    return n + n + 1 + 2 + 1;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for packed ALU commands; head word is visible
// combinationally on dout whenever the FIFO is non-empty.
`timescale 1ns/1ps
module alu_cmd_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO refuses a push even when a pop happens on the same edge
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the N-bit ALU: queues commands, issues one at a time,
// waits the ALU latency and returns Sum/Cout plus a zero flag in order.
`timescale 1ns/1ps
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int N       = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         Clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_cin,
  input  logic [1:0]   cmd_oper,
  input  logic         cmd_mode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [1:0]   alu_oper,
  output logic         alu_mode,
  input  logic [N-1:0] alu_sum,
  input  logic         alu_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_sum,
  output logic         res_cout,
  output logic         res_zero,
  output logic         busy
);

  localparam int CMD_W = cmd_width(N);
  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  function automatic logic sum_is_zero(input logic [N-1:0] s);
    return (s == '0);
  endfunction

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              capture;
  logic              release_res;
  logic [CMD_W-1:0]  fifo_din;
  logic [CMD_W-1:0]  fifo_dout;
  logic [N-1:0]      head_a;
  logic [N-1:0]      head_b;
  logic              head_cin;
  logic [1:0]        head_oper;
  logic              head_mode;

  assign cmd_ready = rst_n && !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign fifo_din  = {cmd_a, cmd_b, cmd_cin, cmd_oper, cmd_mode};
  assign {head_a, head_b, head_cin, head_oper, head_mode} = fifo_dout;
  assign busy      = rst_n && ((state_q != ST_IDLE) || !fifo_empty);

  alu_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          release_res = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue stage: alu_* only move on a pop, so they stay frozen through WAIT
  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
      alu_oper <= '0;
      alu_mode <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        alu_a    <= head_a;
        alu_b    <= head_b;
        alu_cin  <= head_cin;
        alu_oper <= head_oper;
        alu_mode <= head_mode;
        cnt_q    <= CNT_W'(ALU_LAT);
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Result stage: zero flag looks at the N-bit sum only, never at Cout
  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_zero  <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_sum   <= alu_sum;
      res_cout  <= alu_cout;
      res_zero  <= sum_is_zero(alu_sum);
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a registered ALU stand-in.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int N       = 4;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [1:0]   oper;
    logic         mode;
  } cmd_t;

  typedef struct {
    cmd_t         c;
    logic [N-1:0] sum;
    logic         cout;
  } exp_t;

  logic         Clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [N-1:0] cmd_a = '0;
  logic [N-1:0] cmd_b = '0;
  logic         cmd_cin = 1'b0;
  logic [1:0]   cmd_oper = '0;
  logic         cmd_mode = 1'b0;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_cin;
  logic [1:0]   alu_oper;
  logic         alu_mode;
  logic [N-1:0] alu_sum = '0;
  logic         alu_cout = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [N-1:0] res_sum;
  logic         res_cout;
  logic         res_zero;
  logic         busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   hs_cyc[$];
  exp_t e_mon;
  exp_t e_new;

  alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .cmd_oper(cmd_oper), .cmd_mode(cmd_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_oper(alu_oper), .alu_mode(alu_mode),
    .alu_sum(alu_sum), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_zero(res_zero),
    .busy(busy)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural ALU: {cout, sum} for a command
  function automatic logic [N:0] alu_func(input cmd_t c);
    logic [N:0] r;
    if (c.mode == MODE_ARITH) begin
      case (c.oper)
        OPER_PASS_A: r = (N+1)'(c.a);
        OPER_ADD:    r = (N+1)'(c.a) + (N+1)'(c.b) + (N+1)'(c.cin);
        OPER_SUB_AB: r = (N+1)'(c.a) + {1'b0, ~c.b} + (N+1)'(1);
        default:     r = (N+1)'(c.b) + {1'b0, ~c.a} + (N+1)'(1);
      endcase
    end else begin
      case (c.oper)
        OPER_AND: r = {1'b0, c.a & c.b};
        OPER_OR:  r = {1'b0, c.a | c.b};
        OPER_XOR: r = {1'b0, c.a ^ c.b};
        default:  r = {1'b0, ~(c.a ^ c.b)};
      endcase
    end
    return r;
  endfunction

  // Registered ALU (latency 1) driven by the sequencer
  always @(posedge Clk) begin
    {alu_cout, alu_sum} <= alu_func(cmd_t'({alu_a, alu_b, alu_cin, alu_oper, alu_mode}));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Recorder and monitor: sampled mid-cycle, describes what the next edge does
  always @(negedge Clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (res_valid && res_ready) begin
        hs_cyc.push_back(cyc + 1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected actual sum=%0d cout=%0d required=no result", res_sum, res_cout);
        end else begin
          e_mon = sb.pop_front();
          chk("res_sum",  32'(res_sum),  32'(e_mon.sum));
          chk("res_cout", 32'(res_cout), 32'(e_mon.cout));
          chk("res_zero", 32'(res_zero), 32'(e_mon.sum == '0));
          chk("alu_hold", 32'({alu_a, alu_b, alu_cin, alu_oper, alu_mode}), 32'(e_mon.c));
        end
      end
      if (cmd_valid && cmd_ready) begin
        e_new.c = cmd_t'({cmd_a, cmd_b, cmd_cin, cmd_oper, cmd_mode});
        {e_new.cout, e_new.sum} = alu_func(e_new.c);
        sb.push_back(e_new);
      end
    end
  end

  task automatic drive_cmd(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                           input logic [1:0] oper, input logic mode);
    cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_oper = oper; cmd_mode = mode;
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic wait_res_valid(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    if (!res_valid) chk(name, 32'(res_valid), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge Clk); #1;
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
    idle(4);
  endtask

  initial begin
    int k;
    // Reset state
    idle(3);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, alu_cin, alu_oper, alu_mode}), 32'd0);
    chk("rst_res_sum", 32'(res_sum), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    idle(2);

    // Single op and its latency
    res_ready = 1'b1;
    k = cyc + 1;
    drive_cmd(4'd3, 4'd6, 1'b0, OPER_ADD, MODE_ARITH);
    cmd_valid = 1'b0;
    wait_res_valid("single_timeout");
    chk("single_latency", 32'(cyc), 32'(k + 3));
    chk("single_sum", 32'(res_sum), 32'd9);
    chk("single_cout", 32'(res_cout), 32'd0);
    chk("single_zero", 32'(res_zero), 32'd0);
    drain("single_drain");

    // Carry out with an all-zero sum
    drive_cmd(4'd10, 4'd5, 1'b1, OPER_ADD, MODE_ARITH);
    cmd_valid = 1'b0;
    wait_res_valid("carry_timeout");
    chk("carry_sum", 32'(res_sum), 32'd0);
    chk("carry_cout", 32'(res_cout), 32'd1);
    chk("carry_zero", 32'(res_zero), 32'd1);
    drain("carry_drain");

    // Logic ops back to back: one result every three cycles
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) drive_cmd(4'd8, 4'd11, 1'b0, 2'(i), MODE_LOGIC);
    cmd_valid = 1'b0;
    k = 0;
    while (hs_cyc.size() < 4 && k < 60) begin
      @(posedge Clk); #1;
      k++;
    end
    chk("logic_count", 32'(hs_cyc.size()), 32'd4);
    if (hs_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) chk("logic_interval", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
    end
    drain("logic_drain");

    // Back-pressure: one in flight plus a full FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      drive_cmd(4'($urandom), 4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
    cmd_valid = 1'b0;
    #1;
    chk("bp_full_ready", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) drive_cmd(4'd15, 4'd15, 1'b1, OPER_XNOR, MODE_LOGIC);
    chk("bp_still_full", 32'(cmd_ready), 32'd0);
    chk("bp_queued", 32'(sb.size()), 32'd5);
    hs_cyc.delete();
    drain("bp_drain");
    chk("bp_delivered", 32'(hs_cyc.size()), 32'd5);

    // Push on the HOLD handshake edge with two entries queued
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_cmd(4'(i + 1), 4'(i + 7), 1'b0, OPER_ADD, MODE_ARITH);
    cmd_valid = 1'b0;
    wait_res_valid("pp_timeout");
    res_ready = 1'b1;
    drive_cmd(4'd12, 4'd2, 1'b0, OPER_SUB_AB, MODE_ARITH);
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("pp_ready_after", 32'(cmd_ready), 32'd1);
    drive_cmd(4'd1, 4'd1, 1'b0, OPER_SUB_BA, MODE_ARITH);
    cmd_valid = 1'b0;
    #1;
    chk("pp_ready_three", 32'(cmd_ready), 32'd1);
    drive_cmd(4'd5, 4'd9, 1'b0, OPER_OR, MODE_LOGIC);
    cmd_valid = 1'b0;
    #1;
    chk("pp_ready_four", 32'(cmd_ready), 32'd0);
    drain("pp_drain");

    // Reset in the middle of WAIT with two commands queued
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_cmd(4'(i + 2), 4'd3, 1'b0, OPER_ADD, MODE_ARITH);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("rw_ready_in_reset", 32'(cmd_ready), 32'd0);
    @(posedge Clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rw_res_valid", 32'(res_valid), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_cmd_ready", 32'(cmd_ready), 32'd1);
    hs_cyc.delete();
    idle(20);
    chk("rw_no_stale", 32'(hs_cyc.size()), 32'd0);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      cmd_cin   = 1'($urandom);
      cmd_oper  = 2'($urandom);
      cmd_mode  = 1'($urandom);
      cmd_valid = ($urandom_range(0, 9) < 6);
      res_ready = ($urandom_range(0, 9) < 7);
      @(posedge Clk); #1;
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the team's N-bit ALU. It accepts ALU commands (operands, carry-in, Oper, Mode) over a valid/ready interface and buffers them in a small FIFO. It issues one command at a time to the ALU, waits the ALU's fixed latency, and captures Sum/Cout. Results are returned in order with flags over a second valid/ready interface.

Parameters:
N, 4, operand/result width in bits
DEPTH, 4, command FIFO entries (power of 2, >=2)
ALU_LAT, 1, clock edges from operands applied to ALU until Sum/Cout valid (>=0; the registered ALU = 1)

Ports:
Clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full; forced 0 while rst_n=0
cmd_a  in  N  operand A
cmd_b  in  N  operand B
cmd_cin  in  1  carry-in
cmd_oper  in  2  ALU Oper code
cmd_mode  in  1  1=arithmetic, 0=logic
alu_a  out  N  to ALU A
alu_b  out  N  to ALU B
alu_cin  out  1  to ALU Cin
alu_oper  out  2  to ALU Oper
alu_mode  out  1  to ALU Mode
alu_sum  in  N  from ALU Sum
alu_cout  in  1  from ALU Cout
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_sum  out  N  captured Sum
res_cout  out  1  captured Cout
res_zero  out  1  1 when res_sum==0
busy  out  1  state!=IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n=0 at a rising edge): FIFO emptied; state=IDLE; all alu_*, res_* outputs, and busy = 0. Reset mid-operation discards queued and in-flight commands. res_valid drops after that edge.
- Push: cmd_valid & cmd_ready at an edge writes the command. There is no write-through: a command cannot be issued on the edge it is pushed.
- cmd_ready = !full, combinational from the occupancy count. Push and pop on the same edge leaves the count unchanged. When full, a push is refused even if a pop happens the same edge.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into the alu_* registers, set cnt=ALU_LAT, go to WAIT.
  - WAIT: while cnt!=0, decrement. At the edge with cnt==0, capture alu_sum/alu_cout into res_sum/res_cout, compute res_zero from the captured sum, set res_valid=1, go to HOLD.
  - HOLD: res_* stable while res_valid & !res_ready. On the edge with res_valid & res_ready: clear res_valid. If the FIFO is non-empty, pop the next command into alu_* on the same edge, set cnt=ALU_LAT, go to WAIT. Otherwise go to IDLE.
- alu_* outputs hold the last issued command until the next pop. They never change during WAIT.
- Latency (empty FIFO, IDLE, ALU_LAT=L): push at edge k -> issue at k+1 -> res_valid high after edge k+2+L.
- Back-to-back throughput with res_ready=1 is one result per L+2 cycles.
- res_zero reflects the N-bit sum only; Cout is ignored, so 4'b0000 with Cout=1 gives zero=1.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- Results leave strictly in push order.

Decomposition:
- Shared package alu_pkg: Oper codes (arithmetic: 00 transfer A, 01 A+B+Cin, 10 A-B, 11 B-A; logic: 00 AND, 01 OR, 10 XOR, 11 XNOR), MODE_ARITH=1/MODE_LOGIC=0, the FSM state encoding, and the packed command width N+N+1+2+1.
- One sub-module: alu_cmd_fifo, a synchronous FIFO of DEPTH packed commands with push/pop/full/empty and synchronous active-low reset.

Test Plan:
- Bench uses the registered ALU (ALU_LAT=1).
- Single op: push Mode=1 Oper=01 A=3 B=6 Cin=0 at edge k, res_ready=1 -> res_valid after edge k+3, res_sum=9, res_cout=0, res_zero=0.
- Carry/zero: Mode=1 Oper=01 A=10 B=5 Cin=1 -> res_sum=0, res_cout=1, res_zero=1.
- Logic sequence: push AND, OR, XOR, XNOR with A=8 B=11 back-to-back -> results 8, 11, 3, 12 in order, one every 3 cycles, alu_* stable during each WAIT.
- Back-pressure: res_ready=0, push 5 commands -> 1 issued plus 4 queued, cmd_ready=0 and further pushes refused. Then res_ready=1 -> all 5 results delivered in order, with the refused push absent.
- Simultaneous push/pop: with FIFO at 2 entries, push on the HOLD handshake edge -> count stays 2, cmd_ready stays 1.
- Reset mid-WAIT: rst_n=0 for one edge during WAIT with 2 queued -> res_valid=0, busy=0, cmd_ready=1 after reset release, and no stale result is ever emitted.
